// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: hazard and stall sequencer for the 5-stage core.
// Produces the load/clear controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// It resolves load-use, taken-branch, I-miss, D-miss and halt.
// Optional: define PIPE_STALL_CNT_EN to add three saturating stall counters.
module pipe_stall_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_miss,
    input  logic        icache_done,
    input  logic        dcache_miss,
    input  logic        dcache_done,
    input  logic        branch_taken,
    input  logic        id_ex_memrd,
    input  logic [3:0]  id_ex_rd,
    input  logic [3:0]  if_id_rs,
    input  logic [3:0]  if_id_rt,
    input  logic        rs_used,
    input  logic        rt_used,
    input  logic        halt_wb,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        if_id_clr,
    output logic        id_ex_we,
    output logic        id_ex_clr,
    output logic        ex_mem_we,
    output logic        mem_wb_clr,
    output logic        halted
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt_i,
    output logic [15:0] stall_cnt_d,
    output logic [15:0] stall_cnt_lu
`endif
);

    typedef enum logic [1:0] {RUN, IMISS, DMISS, HALT} state_t;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_clr;
        logic id_ex_we;
        logic id_ex_clr;
        logic ex_mem_we;
        logic mem_wb_clr;
        logic halted;
    } ctrl_t;

    // Everything advances, nothing cleared.
    localparam ctrl_t CTRL_RUN = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_clr: 1'b0,
                                   id_ex_we: 1'b1, id_ex_clr: 1'b0, ex_mem_we: 1'b1,
                                   mem_wb_clr: 1'b0, halted: 1'b0};
    // Whole pipe holds; WB sees a bubble so nothing retires twice.
    localparam ctrl_t CTRL_FRZ = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_clr: 1'b0,
                                   id_ex_we: 1'b0, id_ex_clr: 1'b0, ex_mem_we: 1'b0,
                                   mem_wb_clr: 1'b1, halted: 1'b0};
    // Values held while rst is asserted.
    localparam ctrl_t CTRL_RST = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_clr: 1'b1,
                                   id_ex_we: 1'b0, id_ex_clr: 1'b1, ex_mem_we: 1'b0,
                                   mem_wb_clr: 1'b1, halted: 1'b0};

    state_t state, state_nxt;
    logic   ipend, ipend_nxt;
    logic   ipend_eff;
    logic   lu;
    ctrl_t  ctl;

    // Load-use: a load in EX writes a register the ID instruction reads; r0 never hazards.
    assign lu = id_ex_memrd && (id_ex_rd != 4'd0) &&
                ((rs_used && (if_id_rs == id_ex_rd)) || (rt_used && (if_id_rt == id_ex_rd)));

    // An I-fill that lands in the same cycle the D-miss releases needs no IMISS pass.
    assign ipend_eff = ipend && !icache_done;

    // State and pending-I-miss flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            ipend <= 1'b0;
        end else begin
            state <= state_nxt;
            ipend <= ipend_nxt;
        end
    end

    // Next state and Mealy controls; halt > D-miss > load-use > branch > I-miss.
    always_comb begin
        ctl       = CTRL_RUN;
        state_nxt = state;
        ipend_nxt = ipend;
        case (state)
            RUN: begin
                if (halt_wb) begin
                    ctl       = CTRL_FRZ;
                    state_nxt = HALT;
                end else if (dcache_miss) begin
                    ctl       = CTRL_FRZ;
                    state_nxt = DMISS;
                    ipend_nxt = icache_miss;
                end else if (lu) begin
                    ctl.pc_we     = 1'b0;
                    ctl.if_id_we  = 1'b0;
                    ctl.id_ex_clr = 1'b1;
                end else if (branch_taken) begin
                    // PC takes the target; a simultaneous miss is on the target fetch.
                    ctl.if_id_clr = 1'b1;
                    if (icache_miss)
                        state_nxt = IMISS;
                end else if (icache_miss) begin
                    ctl.pc_we     = 1'b0;
                    ctl.if_id_clr = 1'b1;
                    state_nxt     = IMISS;
                end
            end
            IMISS: begin
                if (halt_wb) begin
                    ctl       = CTRL_FRZ;
                    state_nxt = HALT;
                end else if (dcache_miss) begin
                    ctl       = CTRL_FRZ;
                    state_nxt = DMISS;
                    ipend_nxt = !icache_done;
                end else if (icache_done) begin
                    // Fetched instruction is valid: behave as RUN for this cycle.
                    state_nxt = RUN;
                    if (lu) begin
                        ctl.pc_we     = 1'b0;
                        ctl.if_id_we  = 1'b0;
                        ctl.id_ex_clr = 1'b1;
                    end else if (branch_taken) begin
                        ctl.if_id_clr = 1'b1;
                    end
                end else begin
                    // Fetch outstanding: feed NOPs into ID, let the back end drain.
                    ctl.pc_we     = 1'b0;
                    ctl.if_id_clr = 1'b1;
                    if (lu) begin
                        ctl.if_id_clr = 1'b0;
                        ctl.if_id_we  = 1'b0;
                        ctl.id_ex_clr = 1'b1;
                    end else if (branch_taken) begin
                        ctl.pc_we = 1'b1;
                    end
                end
            end
            DMISS: begin
                if (halt_wb) begin
                    ctl       = CTRL_FRZ;
                    state_nxt = HALT;
                end else if (dcache_done) begin
                    // Release cycle: everything advances; an outstanding fetch keeps IF empty.
                    ipend_nxt = 1'b0;
                    state_nxt = ipend_eff ? IMISS : RUN;
                    if (ipend_eff) begin
                        ctl.pc_we     = 1'b0;
                        ctl.if_id_clr = 1'b1;
                    end
                    if (lu) begin
                        ctl.pc_we     = 1'b0;
                        ctl.if_id_we  = 1'b0;
                        ctl.if_id_clr = 1'b0;
                        ctl.id_ex_clr = 1'b1;
                    end else if (branch_taken) begin
                        ctl.pc_we     = 1'b1;
                        ctl.if_id_clr = 1'b1;
                    end
                end else begin
                    ctl = CTRL_FRZ;
                    // Fill landed while frozen: the line is resident, the refetch hits.
                    if (icache_done)
                        ipend_nxt = 1'b0;
                end
            end
            HALT: begin
                ctl        = CTRL_FRZ;
                ctl.halted = 1'b1;
            end
            default: begin
                state_nxt = RUN;
                ipend_nxt = 1'b0;
            end
        endcase
        if (rst)
            ctl = CTRL_RST;
    end

    assign pc_we      = ctl.pc_we;
    assign if_id_we   = ctl.if_id_we;
    assign if_id_clr  = ctl.if_id_clr;
    assign id_ex_we   = ctl.id_ex_we;
    assign id_ex_clr  = ctl.id_ex_clr;
    assign ex_mem_we  = ctl.ex_mem_we;
    assign mem_wb_clr = ctl.mem_wb_clr;
    assign halted     = ctl.halted;

`ifdef PIPE_STALL_CNT_EN
    logic lu_stall;

    // A bubble into ID/EX outside reset only ever comes from a load-use stall.
    assign lu_stall = lu && ctl.id_ex_clr;

    // Saturating stall counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_i  <= 16'd0;
            stall_cnt_d  <= 16'd0;
            stall_cnt_lu <= 16'd0;
        end else begin
            if (state == IMISS && stall_cnt_i != 16'hFFFF)
                stall_cnt_i <= stall_cnt_i + 16'd1;
            if (state == DMISS && stall_cnt_d != 16'hFFFF)
                stall_cnt_d <= stall_cnt_d + 16'd1;
            if (lu_stall && stall_cnt_lu != 16'hFFFF)
                stall_cnt_lu <= stall_cnt_lu + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; control word compared as
// {pc_we, if_id_we, if_id_clr, id_ex_we, id_ex_clr, ex_mem_we, mem_wb_clr, halted}.
module tb_pipe_stall_ctrl;

    localparam logic [7:0] E_RUN = 8'b1101_0100;
    localparam logic [7:0] E_RST = 8'b0010_1010;
    localparam logic [7:0] E_LU  = 8'b0001_1100;
    localparam logic [7:0] E_BR  = 8'b1111_0100;
    localparam logic [7:0] E_IMS = 8'b0111_0100;
    localparam logic [7:0] E_FRZ = 8'b0000_0010;
    localparam logic [7:0] E_HLT = 8'b0000_0011;

    logic clk, rst;
    logic icache_miss, icache_done, dcache_miss, dcache_done, branch_taken;
    logic id_ex_memrd, rs_used, rt_used, halt_wb;
    logic [3:0] id_ex_rd, if_id_rs, if_id_rt;
    logic pc_we, if_id_we, if_id_clr, id_ex_we, id_ex_clr, ex_mem_we, mem_wb_clr, halted;
    logic [7:0] ctl;
`ifdef PIPE_STALL_CNT_EN
    logic [15:0] stall_cnt_i, stall_cnt_d, stall_cnt_lu;
    logic [15:0] c0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pipe_stall_ctrl dut (
        .clk(clk), .rst(rst),
        .icache_miss(icache_miss), .icache_done(icache_done),
        .dcache_miss(dcache_miss), .dcache_done(dcache_done),
        .branch_taken(branch_taken),
        .id_ex_memrd(id_ex_memrd), .id_ex_rd(id_ex_rd),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .rs_used(rs_used), .rt_used(rt_used), .halt_wb(halt_wb),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_clr(if_id_clr),
        .id_ex_we(id_ex_we), .id_ex_clr(id_ex_clr), .ex_mem_we(ex_mem_we),
        .mem_wb_clr(mem_wb_clr), .halted(halted)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt_i(stall_cnt_i), .stall_cnt_d(stall_cnt_d), .stall_cnt_lu(stall_cnt_lu)
`endif
    );

    assign ctl = {pc_we, if_id_we, if_id_clr, id_ex_we, id_ex_clr, ex_mem_we, mem_wb_clr, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs were just set after a falling edge; check the Mealy outputs, move to next falling edge.
    task automatic step(input string tag, input logic [7:0] exp);
        #1;
        chk(tag, {24'd0, ctl}, {24'd0, exp});
        @(negedge clk);
    endtask

    task automatic idle();
        icache_miss = 0; icache_done = 0; dcache_miss = 0; dcache_done = 0;
        branch_taken = 0; id_ex_memrd = 0; id_ex_rd = 0; if_id_rs = 0; if_id_rt = 0;
        rs_used = 0; rt_used = 0; halt_wb = 0;
    endtask

    task automatic set_lu_rs(input logic [3:0] rd);
        id_ex_memrd = 1; id_ex_rd = rd; if_id_rs = rd; rs_used = 1;
    endtask

    initial begin
        idle();
        rst = 1;
        @(negedge clk);
        // reset
        step("rst_out", E_RST);
        icache_miss = 1;
        step("rst_out_ign", E_RST);
        icache_miss = 0; rst = 0;
`ifdef PIPE_STALL_CNT_EN
        #1;
        chk("cnt_i_rst", {16'd0, stall_cnt_i}, 32'd0);
        chk("cnt_d_rst", {16'd0, stall_cnt_d}, 32'd0);
        chk("cnt_lu_rst", {16'd0, stall_cnt_lu}, 32'd0);
        c0 = stall_cnt_lu;
`endif
        step("run_idle", E_RUN);

        // load-use
        set_lu_rs(4'd3);
        step("lu_rs", E_LU);
        idle();
        step("lu_one_cycle", E_RUN);
`ifdef PIPE_STALL_CNT_EN
        chk("cnt_lu_1", {16'd0, stall_cnt_lu - c0}, 32'd1);
`endif
        set_lu_rs(4'd0);
        step("lu_r0", E_RUN);
        idle(); id_ex_memrd = 1; id_ex_rd = 4'd5; if_id_rt = 4'd5; rt_used = 1;
        step("lu_rt", E_LU);
        rt_used = 0;
        step("lu_rt_unused", E_RUN);
        idle(); id_ex_rd = 4'd7; if_id_rs = 4'd7; rs_used = 1;
        step("lu_no_load", E_RUN);

        // branch
        idle(); branch_taken = 1;
        step("br", E_BR);
        idle();
        step("br_one_cycle", E_RUN);
        set_lu_rs(4'd2); branch_taken = 1;
        step("br_lu", E_LU);
        idle(); branch_taken = 1; icache_miss = 1;
        step("br_imiss", E_BR);
        idle();
        step("br_imiss_wait", E_IMS);
        icache_done = 1;
        step("br_imiss_done", E_RUN);
        idle();
        step("br_imiss_run", E_RUN);

        // I-miss, 4 idle cycles, fill
`ifdef PIPE_STALL_CNT_EN
        c0 = stall_cnt_i;
`endif
        icache_miss = 1;
        step("imiss0", E_IMS);
        icache_miss = 0;
        for (int i = 0; i < 4; i++) step("imiss_wait", E_IMS);
        icache_done = 1;
        step("imiss_done", E_RUN);
`ifdef PIPE_STALL_CNT_EN
        chk("cnt_i_5", {16'd0, stall_cnt_i - c0}, 32'd5);
`endif
        idle();
        step("imiss_run", E_RUN);

        // overrides inside IMISS
        icache_miss = 1;
        step("imiss1", E_IMS);
        idle(); set_lu_rs(4'd4);
        step("imiss_lu", E_LU);
        idle(); branch_taken = 1;
        step("imiss_br", E_BR);
        idle(); icache_done = 1;
        step("imiss1_done", E_RUN);
        idle();

        // D-miss during I-miss, release 3 cycles later, back to IMISS
        icache_miss = 1;
        step("imiss2", E_IMS);
        idle(); dcache_miss = 1;
        step("dm_in_im", E_FRZ);
        idle();
        step("dm_frz1", E_FRZ);
        step("dm_frz2", E_FRZ);
        dcache_done = 1;
        step("dm_release_ipend", E_IMS);
        idle();
        step("dm_back_imiss", E_IMS);
        icache_done = 1;
        step("dm_im_done", E_RUN);
        idle();
        step("dm_im_run", E_RUN);

        // plain D-miss from RUN
`ifdef PIPE_STALL_CNT_EN
        c0 = stall_cnt_d;
`endif
        dcache_miss = 1;
        step("dm0", E_FRZ);
        idle();
        step("dm0_frz", E_FRZ);
        dcache_done = 1;
        step("dm0_release", E_RUN);
`ifdef PIPE_STALL_CNT_EN
        chk("cnt_d_2", {16'd0, stall_cnt_d - c0}, 32'd2);
`endif
        idle();
        step("dm0_run", E_RUN);

        // D-miss with I-miss pending; I-fill lands while frozen -> straight back to RUN
        dcache_miss = 1; icache_miss = 1;
        step("dm_ip", E_FRZ);
        idle(); icache_done = 1;
        step("dm_ip_ifill", E_FRZ);
        idle(); dcache_done = 1;
        step("dm_ip_release", E_RUN);
        idle();
        step("dm_ip_run", E_RUN);

        // halt
        halt_wb = 1;
        @(negedge clk);
        idle();
        for (int i = 0; i < 10; i++) begin
            icache_miss = i[0];
            dcache_miss = i[1];
            step("halt", E_HLT);
        end
        idle(); rst = 1;
        step("halt_rst", E_RST);
        rst = 0;
        step("halt_rst_run", E_RUN);

        // asynchronous reset in the middle of a D-miss
        dcache_miss = 1;
        step("dm_rst0", E_FRZ);
        idle();
        step("dm_rst_frz", E_FRZ);
        rst = 1;
        step("dm_rst_async", E_RST);
        rst = 0;
        step("dm_rst_run", E_RUN);
        step("dm_rst_run2", E_RUN);

`ifdef PIPE_STALL_CNT_EN
        // saturation of the D-miss counter
        dcache_miss = 1;
        step("sat_dm", E_FRZ);
        idle();
        repeat (70000) @(negedge clk);
        #1;
        chk("sat_frz", {24'd0, ctl}, {24'd0, E_FRZ});
        chk("cnt_d_sat", {16'd0, stall_cnt_d}, 32'h0000_FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline hazard and stall sequencer for the 5-stage core with instruction and data caches. It generates write-enable and clear controls for the PC, the IF/ID register, the ID/EX register, the EX/MEM register and the MEM/WB register. It resolves load-use hazards, taken-branch flushes, I-cache and D-cache miss stalls, and halt. It sits beside the hazard-detection logic and drives the pipeline registers directly.

## Interface
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `icache_miss` in 1: fetch missed this cycle.
- `icache_done` in 1: I-cache fill complete; the instruction is valid this cycle.
- `dcache_miss` in 1: MEM-stage access missed.
- `dcache_done` in 1: D-cache fill complete; MEM data is valid this cycle.
- `branch_taken` in 1: branch/jump resolved taken in ID.
- `id_ex_memrd` in 1: instruction in EX is a load.
- `id_ex_rd` in 4: destination of the EX load.
- `if_id_rs`, `if_id_rt` in 4 each: sources of the ID instruction.
- `rs_used`, `rt_used` in 1 each: the ID instruction reads rs/rt.
- `halt_wb` in 1: HLT instruction is in WB.
- `pc_we` out 1: PC register load.
- `if_id_we`, `if_id_clr` out 1 each: IF/ID controls; clr overrides we (inserts NOP).
- `id_ex_we`, `id_ex_clr` out 1 each: ID/EX controls; clr inserts a bubble.
- `ex_mem_we` out 1: EX/MEM load.
- `mem_wb_clr` out 1: MEM/WB bubble.
- `halted` out 1: core halted.
- `stall_cnt_i`, `stall_cnt_d`, `stall_cnt_lu` out 16 each: only present with `PIPE_STALL_CNT_EN`.

## Operation
- State register has four states: RUN, IMISS, DMISS, HALT. There is also a 1-bit `ipend` flag (I-miss outstanding).
- Load-use hazard: `lu = id_ex_memrd & (id_ex_rd != 0) & ((rs_used & rs==rd) | (rt_used & rt==rd))`. Register 0 never hazards.
- Default outputs: all `*_we` = 1, all `*_clr` = 0.
- Priority within a cycle, highest first: HALT > DMISS/`dcache_miss` > `lu` > `branch_taken` > I-miss.
- **RUN**:
  - `halt_wb` → HALT.
  - Else `dcache_miss` → DMISS. This cycle: freeze outputs, and set `ipend` if `icache_miss`.
  - Else `lu`: `pc_we=0`, `if_id_we=0`, `id_ex_clr=1`. `branch_taken` is ignored this cycle.
  - Else `branch_taken`: `pc_we=1`, `if_id_clr=1`.
  - Else `icache_miss` → IMISS. This cycle: `pc_we=0`, `if_id_clr=1`.
  - `branch_taken` together with `icache_miss`: PC loads the target, IF/ID is cleared, and the state goes to IMISS.
- **IMISS**:
  - `pc_we=0` and `if_id_clr=1` each cycle; downstream stages advance.
  - `lu` overrides: `if_id_clr=0`, `if_id_we=0`, `id_ex_clr=1`.
  - `branch_taken`: `pc_we=1`.
  - `icache_done` with no `dcache_miss`: defaults (`pc_we=1`, `if_id_we=1`), next state RUN.
  - `dcache_miss` → DMISS with `ipend=1`, unless `icache_done` occurs in the same cycle.
- **DMISS**:
  - Freeze outputs each cycle: `pc_we=0`, `if_id_we=0`, `id_ex_we=0`, `ex_mem_we=0`, `mem_wb_clr=1`.
  - `icache_done` seen in DMISS clears `ipend`. The line is then resident and the refetch hits.
  - On `dcache_done`: `mem_wb_clr=0` and all stages advance. This cycle also evaluates `lu`/`branch_taken` exactly as in RUN. Next state is IMISS if `ipend`, else RUN.
- **HALT**:
  - Sticky until `rst`.
  - All `we`=0, `mem_wb_clr=1`, `halted=1`; all inputs ignored.

## Timing
- State and `ipend` are registered. Controls are combinational (Mealy) from state plus the current inputs, with zero-cycle latency to the pipeline registers.
- Reset (asynchronous, during `rst`):
  - State RUN, `ipend=0`.
  - Outputs forced: `pc_we=0`, `if_id_we=0`, `id_ex_we=0`, `ex_mem_we=0`, `if_id_clr=1`, `id_ex_clr=1`, `mem_wb_clr=1`, `halted=0`.
- First edge after `rst` deasserts: normal RUN evaluation.
- Reset mid-miss returns to RUN immediately and clears `ipend`. The caches are reset by the same `rst`.
- Load-use stall lasts exactly 1 cycle: the bubble moves `id_ex_memrd` out of EX.
- A D-miss of N cycles (`dcache_miss` followed N−1 cycles later by `dcache_done`) freezes the pipe for N−1 cycles plus the advance cycle.

## Configuration
- `PIPE_STALL_CNT_EN` defined: three 16-bit saturating counters, cleared by `rst`.
  - `stall_cnt_i` increments each cycle in IMISS.
  - `stall_cnt_d` increments each cycle in DMISS.
  - `stall_cnt_lu` increments each cycle `lu` causes a stall.
  - Each counter holds at 16'hFFFF.
- Undefined: counter ports and logic are absent; behaviour is otherwise identical.

## Test plan
- Load-use: `id_ex_memrd=1`, `id_ex_rd=3`, `if_id_rs=3`, `rs_used=1` → 1 cycle with `pc_we=0`, `if_id_we=0`, `id_ex_clr=1`. With rd=0 → no stall.
- Branch: `branch_taken=1` in RUN → `pc_we=1`, `if_id_clr=1` for 1 cycle. With `lu` also asserted → load-use stall only, `if_id_clr=0`.
- I-miss: `icache_miss` then 4 idle cycles then `icache_done` → `if_id_clr=1` and `pc_we=0` for 5 cycles, then RUN. `stall_cnt_i`=5 when enabled.
- D-miss during I-miss: in IMISS assert `dcache_miss`, `dcache_done` 3 cycles later → full freeze, then return to IMISS. A second `icache_done` → RUN.
- Halt and reset: `halt_wb` → `halted=1`, all `we`=0 for 10 cycles despite `icache_miss` toggling. Pulse `rst` mid-DMISS → reset output values immediately, then RUN.
- Saturation (`PIPE_STALL_CNT_EN`): hold DMISS 70000 cycles → `stall_cnt_d`=16'hFFFF.
